// File: rtl/comparator_pkg.sv
// Shared types and helpers for the chunked sequential magnitude comparator.
// Holds the FSM state encoding, the chunk-count helper and the parameter
// legality check that the top module evaluates at elaboration.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    // Number of CHUNK-wide slices in a WIDTH-bit operand.
    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Legal configuration: at least 2 bits wide and an exact multiple of CHUNK.
    function automatic bit cfg_ok(input int width, input int chunk);
        return (width >= 2) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Purpose: combinational unsigned magnitude compare of one CHUNK-bit slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
// Ports: a, b - slice operands; gr/lt/eq - a>b, a<b, a==b (exactly one is 1).
module comparator_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gr,
    output logic             lt,
    output logic             eq
);

    assign gr = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/comparator_seq.sv
// Purpose: sequential WIDTH-bit signed/unsigned magnitude compare, CHUNK bits per cycle MSB-first, early exit.
// Latency: result valid k cycles after accept, k = position of first differing chunk from MSB (NCHUNK if equal).
// Backpressure: one compare in flight; DONE holds result until out_ready, in_ready returns the cycle after handoff.
// Ports: clk/rst (async active-high); in_valid/in_ready + a, b, is_signed capture a compare;
//        out_valid/out_ready hand off gr/lt/eq, which are 0 whenever out_valid is 0.
module comparator_seq
    import comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gr,
    output logic             lt,
    output logic             eq
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("comparator_seq: WIDTH must be >= 2 and an exact multiple of CHUNK");
    end

    cmp_state_t       state_q;
    cmp_state_t       state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx_q;
    logic             gr_q;
    logic             lt_q;
    logic             eq_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             c_gr;
    logic             c_lt;
    logic             c_eq;
    logic             accept;
    logic             handoff;
    logic [WIDTH-1:0] sign_mask;

    // Flipping the sign bit of both operands maps two's-complement order onto
    // unsigned order, so the datapath below is unsigned only.
    assign sign_mask = {is_signed, {(WIDTH-1){1'b0}}};

    assign accept  = in_valid && in_ready;
    assign handoff = out_valid && out_ready;

    // Single slice comparator, steered by the current chunk index.
    assign a_chunk = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign b_chunk = b_q[int'(idx_q) * CHUNK +: CHUNK];

    comparator_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .gr (c_gr),
        .lt (c_lt),
        .eq (c_eq)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = CMP;
            CMP:  if (!c_eq || (idx_q == '0)) state_d = DONE;
            DONE: if (handoff) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs. Flags are registered and only ever non-zero in DONE.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        gr        = gr_q;
        lt        = lt_q;
        eq        = eq_q;
    end

    // Operand, index and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= '0;
            gr_q  <= 1'b0;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q   <= a ^ sign_mask;
                        b_q   <= b ^ sign_mask;
                        idx_q <= IDX_TOP;
                    end
                end
                CMP: begin
                    if (!c_eq) begin
                        gr_q <= c_gr;
                        lt_q <= c_lt;
                    end else if (idx_q == '0) begin
                        eq_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q - IDXW'(1);
                    end
                end
                DONE: begin
                    if (handoff) begin
                        gr_q <= 1'b0;
                        lt_q <= 1'b0;
                        eq_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_seq.sv
// Purpose: self-checking bench for comparator_seq (WIDTH=32, CHUNK=8).
// Latency: n/a.
// Backpressure: drives out_ready low for a hold window in one directed step.
module tb_comparator_seq;

    localparam int W = 32;
    localparam int C = 8;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic         gr;
    logic         lt;
    logic         eq;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    comparator_seq #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gr        (gr),
        .lt        (lt),
        .eq        (eq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: ordinary integer comparison in the requested mode; latency is
    // the chunk (counted from the MSB) holding the highest differing bit.
    function automatic void ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                    output logic eg, output logic el, output logic ee, output int k);
        logic [W-1:0] d;
        bit           found;
        if (s) begin
            eg = $signed(x) > $signed(y);
            el = $signed(x) < $signed(y);
        end else begin
            eg = x > y;
            el = x < y;
        end
        ee    = (x == y);
        d     = x ^ y;
        k     = N;
        found = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && d[i]) begin
                k     = N - (i / C);
                found = 1;
            end
        end
    endfunction

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold > 0 keeps out_ready low that many cycles after
    // the result appears, pulsing in_valid once during the hold.
    task automatic run_cmp(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic s, input int hold);
        logic eg, el, ee;
        int   k;
        int   lat;
        bit   got;
        ref_cmp(x, y, s, eg, el, ee, k);
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        a         = x;
        b         = y;
        is_signed = s;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        wait_edge();
        in_valid  = 1'b0;
        a         = $urandom;
        b         = $urandom;
        lat = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            wait_edge();
            lat++;
            if (out_valid) got = 1;
        end
        check({tag, " out_valid seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(k));
        check({tag, " flags gr/lt/eq"}, {29'd0, gr, lt, eq}, {29'd0, eg, el, ee});
        check({tag, " one-hot"}, 32'($countones({gr, lt, eq})), 32'd1);
        check({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 1);
            if (i == 1) begin
                a = 32'h0000_0001;
                b = 32'h0000_0002;
            end
            wait_edge();
            in_valid = 1'b0;
            check({tag, " hold stable"}, {28'd0, out_valid, gr, lt, eq}, {28'd0, 1'b1, eg, el, ee});
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        wait_edge();
        check({tag, " after handoff"}, {28'd0, out_valid, gr, lt, eq}, 32'd0);
        check({tag, " in_ready after handoff"}, 32'(in_ready), 32'd1);
        if (hold > 0) begin
            wait_edge();
            check({tag, " pulse not captured"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        end
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        int           mode;
        int           j;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        wait_edge();
        check("reset outputs", {27'd0, in_ready, out_valid, gr, lt, eq}, {27'd0, 5'b10000});
        wait_edge();
        rst = 1'b0;
        wait_edge();
        check("post-reset idle", {27'd0, in_ready, out_valid, gr, lt, eq}, {27'd0, 5'b10000});

        run_cmp("zero eq",      32'h0000_0000, 32'h0000_0000, 1'b0, 0);
        run_cmp("msb unsigned", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0);
        run_cmp("msb signed",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);
        run_cmp("lsb chunk",    32'hCCCC_CCCC, 32'hCCCC_CCCB, 1'b0, 0);
        run_cmp("neg one",      32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        run_cmp("backpressure", 32'h3333_3333, 32'hCCCC_CCCC, 1'b0, 5);

        // Reset while still comparing: nothing may leak out.
        check("rst test in_ready", 32'(in_ready), 32'd1);
        a         = 32'hFFFF_FFFE;
        b         = 32'hFFFF_FFFF;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        wait_edge();
        in_valid = 1'b0;
        wait_edge();
        wait_edge();
        check("mid-cmp busy", {30'd0, in_ready, out_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("async reset outputs", {27'd0, in_ready, out_valid, gr, lt, eq}, {27'd0, 5'b10000});
        wait_edge();
        rst = 1'b0;
        wait_edge();
        check("after reset release", {27'd0, in_ready, out_valid, gr, lt, eq}, {27'd0, 5'b10000});
        run_cmp("eq after reset", 32'h5555_5555, 32'h5555_5555, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            x    = $urandom;
            s    = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            y    = x;
            if (mode == 3) begin
                y = $urandom;
            end else if (mode != 0) begin
                j = $urandom_range(0, N - 1);
                y[j*C +: C] = 8'($urandom);
            end
            run_cmp("random", x, y, s, 0);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
Parametrised, sequential magnitude comparator; successor to the fixed 32-bit combinational gr/lt/eq comparator.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per cycle, and stops early on the first differing chunk.
- Adds a signed/unsigned mode and valid/ready handshakes on input and output.
- Sits between the CORDIC angle/quadrant logic and its control FSM, where wide compares must not sit on the critical path.

Parameters:
- WIDTH, 32, operand width in bits; must be at least 2.
- CHUNK, 8, bits compared per cycle; must divide WIDTH exactly. NCHUNK = WIDTH/CHUNK.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, operands and mode are valid.
- in_ready, output, 1, block can accept a new compare.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- is_signed, input, 1, 1 = two's-complement compare, 0 = unsigned.
- out_valid, output, 1, result is valid.
- out_ready, input, 1, consumer accepts the result.
- gr, output, 1, A > B.
- lt, output, 1, A < B.
- eq, output, 1, A == B.

Behaviour:
- Reset, asynchronous, effective immediately:
  - state = IDLE, in_ready = 1.
  - out_valid, gr, lt, eq = 0.
  - Internal operand registers and chunk index cleared.
- States: IDLE, CMP, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at a rising edge, register a, b and is_signed; chunk index = NCHUNK-1; go to CMP.
- Signed handling: at capture, when is_signed = 1, invert bit WIDTH-1 of both registered operands. An unsigned compare of the result is then exact.
- CMP: each cycle, compare chunk [idx*CHUNK +: CHUNK] of the registered A and B.
  - Chunk differs: set gr or lt from that chunk; go to DONE.
  - Chunk equal and idx == 0: set eq = 1; go to DONE.
  - Otherwise: idx decrements; stay in CMP.
  - in_ready = 0 throughout.
- DONE:
  - out_valid = 1; gr/lt/eq held stable.
  - Exactly one of gr/lt/eq is 1.
  - On out_valid && out_ready: clear out_valid, gr, lt, eq; go to IDLE.
  - in_ready returns to 1 in the following cycle. No accept in the same cycle as the result handoff.
- Latency: with the accept edge at E0, out_valid is first high after edge E0+k.
  - k = 1-based position, counted from the MSB chunk, of the first differing chunk.
  - k = NCHUNK when the operands are equal.
  - Range is 1..NCHUNK. CHUNK == WIDTH gives a fixed latency of 1.
- Throughput: at most one compare in flight. in_valid is ignored whenever in_ready = 0.
- Backpressure: out_ready low holds DONE indefinitely. Outputs must not glitch or change.
- Reset mid-operation (CMP or DONE): transaction is dropped; state and outputs as in the reset bullet. No partial result is ever presented.
- gr/lt/eq are 0 whenever out_valid = 0.

Decomposition:
- Package comparator_pkg:
  - State enum cmp_state_t (IDLE, CMP, DONE).
  - Helper function or localparam for NCHUNK.
  - Elaboration-time checks for WIDTH % CHUNK == 0 and WIDTH >= 2.
- One sub-module, comparator_chunk: purely combinational CHUNK-bit unsigned gr/lt/eq. It is instantiated once and fed by a mux on the chunk index.
- FSM, operand registers and handshake live in comparator_seq.

Test Plan (WIDTH=32, CHUNK=8, NCHUNK=4; out_ready=1 unless stated):
- a=00000000, b=00000000, unsigned -> eq=1, gr=lt=0; out_valid 4 cycles after accept; in_ready high one cycle after handoff.
- a=80000000, b=7FFFFFFF, unsigned -> gr=1, latency 1. Same operands with is_signed=1 -> lt=1, latency 1.
- a=CCCCCCCC, b=CCCCCCCB, unsigned -> gr=1, latency 4. a=FFFFFFFF, b=00000000, signed -> lt=1, latency 1.
- a=33333333, b=CCCCCCCC, then out_ready held low 5 cycles, with in_valid pulsed during the hold:
  - lt=1 and out_valid remain stable for the whole hold.
  - in_ready=0 and the pulsed input is not captured.
  - Release of out_ready -> handoff in 1 cycle.
- a=FFFFFFFE, b=FFFFFFFF, unsigned, rst asserted 2 cycles after accept (still in CMP):
  - out_valid/gr/lt/eq = 0 and in_ready = 1 immediately.
  - Next compare a=55555555, b=55555555 -> eq=1, latency 4.
- Back-to-back randomized compares in both modes against a reference model:
  - Every result matches and exactly one flag is set.
  - Latency equals the first-differing-chunk position.
